// File: rtl/async_fifo_buffer_pkg.sv
// Shared definitions for the elastic req/ack buffer: pop FSM states and
// width helpers derived from the storage depth.
package async_hs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } pop_state_t;

    function automatic int ptr_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic int lvl_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Storage array for async_fifo_buffer: one synchronous write port and one
// combinational read port; contents are not reset.
module async_fifo_mem
    import async_hs_pkg::*;
#(
    parameter int data_width = 32,
    parameter int depth      = 4
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(depth)-1:0]   waddr,
    input  logic [data_width-1:0]     wdata,
    input  logic [ptr_w(depth)-1:0]   raddr,
    output logic [data_width-1:0]     rdata
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/async_fifo_buffer.sv
// Multi-entry elastic buffer for the req/ack dataflow fabric.
// Define FIFO_STATS_EN to add the max_level / stall_cnt statistics ports.
//
//  state | meaning
//  IDLE  | no ack outstanding; waiting for data and all downstream requests
//  ACK   | ack_r high for one cycle; head word presented on dout
module async_fifo_buffer
    import async_hs_pkg::*;
#(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int output_size = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      req_l,
    input  logic                      ack_l,
    input  logic [data_width-1:0]     din,
    input  logic [output_size-1:0]    req_r,
    output logic                      ack_r,
    output logic [data_width-1:0]     dout,
    output logic [lvl_w(depth)-1:0]   level
`ifdef FIFO_STATS_EN
    ,
    output logic [lvl_w(depth)-1:0]   max_level,
    output logic [31:0]               stall_cnt
`endif
);

    localparam int PW = ptr_w(depth);
    localparam int LW = lvl_w(depth);
    localparam logic [LW-1:0] FULL_LVL = LW'(depth);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    pop_state_t    state;
    logic          push;
    logic          pop;
    logic [LW-1:0] level_next;

    assign push = req_l & ack_l;
    assign pop  = (state == ACK);

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (!push && pop) begin
            level_next = level - LW'(1);
        end
    end

    // req_l is only raised when the slot is guaranteed free after this edge,
    // so the head slot can never be overwritten while it is being acked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_l  <= 1'b0;
            wr_ptr <= '0;
        end else if (push) begin
            req_l  <= 1'b0;
            wr_ptr <= wr_ptr + PW'(1);
        end else if (!req_l && (level_next < FULL_LVL)) begin
            req_l  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else begin
            level <= level_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ack_r  <= 1'b0;
            rd_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((level != '0) && (&req_r)) begin
                        state <= ACK;
                        ack_r <= 1'b1;
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    ack_r  <= 1'b0;
                    rd_ptr <= rd_ptr + PW'(1);
                end
                default: begin
                    state <= IDLE;
                    ack_r <= 1'b0;
                end
            endcase
        end
    end

    async_fifo_mem #(
        .data_width (data_width),
        .depth      (depth)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (dout)
    );

`ifdef FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_level <= '0;
            stall_cnt <= '0;
        end else begin
            if (level_next > max_level) begin
                max_level <= level_next;
            end
            if ((level == FULL_LVL) && (ack_l || !req_l) && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_async_fifo_buffer.sv
// Self-checking bench for async_fifo_buffer (depth 4, two downstream
// consumers); exercises the statistics ports when FIFO_STATS_EN is defined.
module tb_async_fifo_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int OS    = 2;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_l;
    logic          ack_l;
    logic [DW-1:0] din;
    logic [OS-1:0] req_r;
    logic          ack_r;
    logic [DW-1:0] dout;
    logic [LW-1:0] level;
`ifdef FIFO_STATS_EN
    logic [LW-1:0] max_level;
    logic [31:0]   stall_cnt;
`endif

    async_fifo_buffer #(
        .data_width  (DW),
        .depth       (DEPTH),
        .output_size (OS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req_l (req_l),
        .ack_l (ack_l),
        .din   (din),
        .req_r (req_r),
        .ack_r (ack_r),
        .dout  (dout),
        .level (level)
`ifdef FIFO_STATS_EN
        ,
        .max_level (max_level),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // producer / consumer control
    logic [DW-1:0] send_q[$];
    logic [DW-1:0] got[$];
    bit            armed;
    bit            stray;
    int            prod_pct;
    bit            cons_rand;
    int            cons_pct;
    logic [OS-1:0] cons_val;
    bit            drop_on_ack;
    int            rises;

    // reference model: occupancy from counted handshakes
    int exp_level;
    int exp_max;
    int exp_stall;
    bit p_push, p_pop, p_full, prev_ack;

    task automatic cycle();
        @(negedge clk);
        if (!rst) begin
            exp_level = 0; exp_max = 0; exp_stall = 0;
            p_push = 0; p_pop = 0; p_full = 0; prev_ack = 0;
        end else begin
            exp_level = exp_level + int'(p_push) - int'(p_pop);
            if (p_full) exp_stall++;
            if (exp_level > exp_max) exp_max = exp_level;
            total++;
            if (level !== LW'(exp_level)) begin
                bad++;
                $display("FAIL level_track t=%0t: level=%0d expected=%0d", $time, level, exp_level);
            end
            total++;
            if (ack_r === 1'b1 && prev_ack) begin
                bad++;
                $display("FAIL ack_pulse_width t=%0t: ack_r high=1 expected=0", $time);
            end
            if (exp_level == DEPTH) begin
                total++;
                if (req_l !== 1'b0) begin
                    bad++;
                    $display("FAIL req_when_full t=%0t: req_l=%0b expected=0", $time, req_l);
                end
            end
`ifdef FIFO_STATS_EN
            total++;
            if (max_level !== LW'(exp_max) || stall_cnt !== 32'(exp_stall)) begin
                bad++;
                $display("FAIL stats_track t=%0t: max_level=%0d stall_cnt=%0d expected %0d %0d",
                         $time, max_level, stall_cnt, exp_max, exp_stall);
            end
`endif
            if (ack_r === 1'b1 && !prev_ack) begin
                rises++;
                got.push_back(dout);
                total++;
                if (exp_level == 0) begin
                    bad++;
                    $display("FAIL ack_when_empty t=%0t: ack_r=1 expected=0", $time);
                end
            end
            p_push   = (req_l === 1'b1) && (ack_l === 1'b1);
            p_pop    = (ack_r === 1'b1);
            p_full   = (exp_level == DEPTH);
            prev_ack = (ack_r === 1'b1);
        end

        @(posedge clk);
        #1;
        if (armed) void'(send_q.pop_front());
        if (stray) begin
            ack_l = 1'b1;
            din   = 32'hDEAD_BEEF;
        end else if (req_l && send_q.size() > 0 && $urandom_range(99) < prod_pct) begin
            ack_l = 1'b1;
            din   = send_q[0];
        end else begin
            ack_l = 1'b0;
            din   = $urandom;
        end
        armed = ack_l && req_l && !stray;
        if (cons_rand) begin
            for (int i = 0; i < OS; i++) req_r[i] = ($urandom_range(99) < cons_pct);
        end else begin
            req_r = cons_val;
        end
        if (drop_on_ack && ack_r) req_r = '0;
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int i;
        for (i = 0; i < budget && got.size() < n; i++) cycle();
        if (got.size() < n) begin
            total++; bad++;
            $display("FAIL %s_timeout: words=%0d expected=%0d", name, got.size(), n);
        end
    endtask

    task automatic wait_level(input int n, input int budget, input string name);
        int i;
        for (i = 0; i < budget && level !== LW'(n); i++) cycle();
        if (level !== LW'(n)) begin
            total++; bad++;
            $display("FAIL %s_timeout: level=%0d expected=%0d", name, level, n);
        end
    endtask

    task automatic test_reset();
        total++;
        if (req_l !== 1'b0 || ack_r !== 1'b0 || level !== '0) begin
            bad++;
            $display("FAIL reset_state: req_l=%0b ack_r=%0b level=%0d expected 0 0 0", req_l, ack_r, level);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        cycle();
        total++;
        if (req_l !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_req: req_l=%0b expected=1", req_l);
        end
    endtask

    task automatic test_latency();
        int i;
        cons_rand = 0; cons_val = '1; prod_pct = 100;
        got.delete();
        send_q.push_back(32'h0000_00A5);
        for (i = 0; i < 20 && !armed; i++) cycle();
        cycle();
        total++;
        if (ack_r !== 1'b0 || level !== LW'(1)) begin
            bad++;
            $display("FAIL latency_n: ack_r=%0b level=%0d expected 0 1", ack_r, level);
        end
        cycle();
        total++;
        if (ack_r !== 1'b1 || dout !== 32'h0000_00A5) begin
            bad++;
            $display("FAIL latency_n1: ack_r=%0b dout=%h expected 1 000000a5", ack_r, dout);
        end
        wait_level(0, 10, "latency_drain");
    endtask

    task automatic test_pass_through();
        cons_rand = 0; cons_val = '1; prod_pct = 100;
        got.delete();
        for (int k = 0; k < 10; k++) send_q.push_back(DW'(k));
        wait_got(10, 200, "pass");
        for (int k = 0; k < 10 && k < got.size(); k++) begin
            total++;
            if (got[k] !== DW'(k)) begin
                bad++;
                $display("FAIL pass_word%0d: dout=%h expected=%h", k, got[k], DW'(k));
            end
        end
        repeat (4) cycle();
        total++;
        if (got.size() != 10) begin
            bad++;
            $display("FAIL pass_count: words=%0d expected=10", got.size());
        end
    endtask

    task automatic test_fill_and_stray();
        cons_rand = 0; cons_val = '0; prod_pct = 100;
        got.delete();
        for (int k = 10; k < 14; k++) send_q.push_back(DW'(k));
        wait_level(4, 40, "fill");
        repeat (3) cycle();
        total++;
        if (level !== LW'(4) || req_l !== 1'b0 || got.size() != 0) begin
            bad++;
            $display("FAIL fill_full: level=%0d req_l=%0b words=%0d expected 4 0 0", level, req_l, got.size());
        end
        stray = 1;
        repeat (5) cycle();
        stray = 0;
        cycle();
        total++;
        if (level !== LW'(4)) begin
            bad++;
            $display("FAIL stray_ack_level: level=%0d expected=4", level);
        end
        cons_val = '1;
        wait_got(4, 60, "fill_drain");
        repeat (6) cycle();
        total++;
        if (got.size() != 4 || level !== '0) begin
            bad++;
            $display("FAIL fill_drain_count: words=%0d level=%0d expected 4 0", got.size(), level);
        end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            total++;
            if (got[k] !== DW'(10 + k)) begin
                bad++;
                $display("FAIL fill_word%0d: dout=%h expected=%h", k, got[k], DW'(10 + k));
            end
        end
    endtask

    task automatic test_fanout();
        int r0;
        cons_rand = 0; cons_val = 2'b01; prod_pct = 100;
        got.delete();
        send_q.push_back(32'h0000_0055);
        wait_level(1, 20, "fanout_load");
        r0 = rises;
        repeat (8) cycle();
        total++;
        if (rises != r0 || level !== LW'(1)) begin
            bad++;
            $display("FAIL fanout_partial: ack_rises=%0d level=%0d expected %0d 1", rises, level, r0);
        end
        cons_val = 2'b10;
        repeat (3) cycle();
        total++;
        if (rises != r0) begin
            bad++;
            $display("FAIL fanout_partial_b: ack_rises=%0d expected=%0d", rises, r0);
        end
        cons_val = 2'b11;
        wait_got(1, 10, "fanout");
        cons_val = 2'b00;
        repeat (4) cycle();
        total++;
        if (rises != r0 + 1 || level !== '0 || got.size() != 1 || got[0] !== 32'h0000_0055) begin
            bad++;
            $display("FAIL fanout_single: ack_rises=%0d level=%0d words=%0d expected %0d 0 1",
                     rises - r0, level, got.size(), 1);
        end
        // consumer withdraws its request while the ack is in flight
        got.delete();
        send_q.push_back(32'h0000_0077);
        wait_level(1, 20, "drop_load");
        cons_val = 2'b11; drop_on_ack = 1;
        wait_got(1, 10, "drop");
        repeat (3) cycle();
        drop_on_ack = 0; cons_val = 2'b00;
        total++;
        if (level !== '0 || got.size() != 1 || got[0] !== 32'h0000_0077) begin
            bad++;
            $display("FAIL req_drop_during_ack: level=%0d words=%0d expected 0 1", level, got.size());
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] sent[$];
        cons_rand = 1; cons_pct = 75; prod_pct = 60;
        got.delete();
        for (int k = 0; k < 40; k++) begin
            sent.push_back($urandom);
            send_q.push_back(sent[k]);
        end
        wait_got(40, 3000, "random");
        for (int k = 0; k < 40 && k < got.size(); k++) begin
            total++;
            if (got[k] !== sent[k]) begin
                bad++;
                $display("FAIL random_word%0d: dout=%h expected=%h", k, got[k], sent[k]);
            end
        end
        cons_rand = 0; cons_val = '1;
        repeat (6) cycle();
        total++;
        if (got.size() != 40 || level !== '0) begin
            bad++;
            $display("FAIL random_count: words=%0d level=%0d expected 40 0", got.size(), level);
        end
    endtask

`ifdef FIFO_STATS_EN
    task automatic test_stats();
        cons_rand = 0; cons_val = '0; prod_pct = 100;
        got.delete();
        for (int k = 0; k < 4; k++) send_q.push_back(DW'(100 + k));
        wait_level(4, 40, "stats_fill");
        repeat (20) cycle();
        total++;
        if (max_level !== LW'(4) || stall_cnt < 32'd20) begin
            bad++;
            $display("FAIL stats_stall: max_level=%0d stall_cnt=%0d expected 4 >=20", max_level, stall_cnt);
        end
        cons_val = '1;
        wait_got(4, 60, "stats_drain");
    endtask
`endif

    task automatic test_reset_mid();
        cons_rand = 0; cons_val = '0; prod_pct = 100;
        for (int k = 0; k < 3; k++) send_q.push_back(DW'(200 + k));
        wait_level(3, 40, "reset_mid_fill");
        #3;
        rst = 1'b0;
        #1;
        total++;
        if (req_l !== 1'b0 || ack_r !== 1'b0 || level !== '0) begin
            bad++;
            $display("FAIL reset_mid_async: req_l=%0b ack_r=%0b level=%0d expected 0 0 0", req_l, ack_r, level);
        end
        send_q.delete();
        armed = 0;
`ifdef FIFO_STATS_EN
        total++;
        if (max_level !== '0 || stall_cnt !== '0) begin
            bad++;
            $display("FAIL reset_mid_stats: max_level=%0d stall_cnt=%0d expected 0 0", max_level, stall_cnt);
        end
`endif
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        total++;
        if (req_l !== 1'b1 || level !== '0) begin
            bad++;
            $display("FAIL reset_mid_release: req_l=%0b level=%0d expected 1 0", req_l, level);
        end
    endtask

    initial begin
        rst = 1'b0; ack_l = 1'b0; din = '0; req_r = '0;
        armed = 0; stray = 0; prod_pct = 100; cons_rand = 0; cons_pct = 50;
        cons_val = '0; drop_on_ack = 0; rises = 0;
        exp_level = 0; exp_max = 0; exp_stall = 0;
        p_push = 0; p_pop = 0; p_full = 0; prev_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_pass_through();
        test_fill_and_stray();
        test_fanout();
        test_random();
`ifdef FIFO_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
